// File: rtl/rd_stream_adapter.sv
// rd_stream_adapter: read-side FIFO output stage presenting popped words on a 2-deep valid/ready stream
module rd_stream_adapter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic                  rempty,
  output logic                  rinc,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [1:0]            level
);
  logic [DATA_WIDTH-1:0] r_buf0, r_buf1, w_buf0_nxt, w_buf1_nxt;
  logic [1:0]            r_held, w_held_nxt;
  logic                  r_inflight, w_pop;
  logic [2:0]            w_credit;
  assign m_data  = r_buf0;
  assign m_valid = r_held != 2'd0;
  assign level   = r_held;
  // Issue a read only when the word it returns is guaranteed a slot; arrivals fill buf0 first, then buf1
  always_comb begin
    w_pop      = m_valid & m_ready;
    w_credit   = {1'b0, r_held} + {2'b0, r_inflight} - {2'b0, w_pop};
    rinc       = r_rst & ~rempty & (w_credit < 3'd2);
    w_buf0_nxt = w_pop ? ((r_inflight && r_held == 2'd1) ? rdata : r_buf1)
                       : ((r_inflight && r_held == 2'd0) ? rdata : r_buf0);
    w_buf1_nxt = (r_inflight && (w_pop ? r_held == 2'd2 : r_held != 2'd0)) ? rdata : r_buf1;
    w_held_nxt = r_held + {1'b0, r_inflight} - {1'b0, w_pop};
  end
  // Buffer, occupancy and in-flight tracking; reset discards everything held or in flight
  always_ff @(posedge r_clk) begin
    if (!r_rst) begin
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_held     <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_buf0     <= w_buf0_nxt;
      r_buf1     <= w_buf1_nxt;
      r_held     <= w_held_nxt;
      r_inflight <= rinc;
    end
  end
endmodule

// File: tb/tb_rd_stream_adapter.sv
// tb_rd_stream_adapter: directed bench with a registered-read FIFO model and an in-order scoreboard
module tb_rd_stream_adapter;
  logic       r_clk, r_rst, rempty, rinc, m_valid, m_ready;
  logic [7:0] rdata, m_data;
  logic [1:0] level;
  int         n_chk, n_err, delivered, rinc_cnt;
  logic [7:0] q[$], sb[$];
  logic [7:0] pend, prev_data;
  bit         pend_v, prev_stall;
  logic       o_rinc, o_valid;
  logic [7:0] o_data;
  logic [1:0] o_level;

  rd_stream_adapter #(.DATA_WIDTH(8)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .rempty(rempty), .rinc(rinc), .rdata(rdata),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .level(level)
  );

  initial begin
    r_clk = 0;
    forever #5 r_clk = ~r_clk;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step(input bit rdy, input bit rst);
    @(negedge r_clk);
    r_rst   = rst;
    m_ready = rdy;
    rempty  = q.size() == 0;
    rdata   = pend_v ? pend : 8'h00;
    #1;
    o_rinc = rinc; o_valid = m_valid; o_data = m_data; o_level = level;
    chk("rinc_while_empty", int'(rinc & rempty), 0);
    chk("credit_bound", int'(int'(level) + int'(pend_v) <= 2), 1);
    if (rst && prev_stall) begin
      chk("stall_valid", int'(m_valid), 1);
      chk("stall_data", int'(m_data), int'(prev_data));
    end
    if (rst && m_valid && m_ready) begin
      if (sb.size() == 0) chk("unexpected_word", int'(m_data), -1);
      else chk("order", int'(m_data), int'(sb.pop_front()));
      delivered++;
    end
    prev_stall = rst && m_valid && !m_ready;
    prev_data  = m_data;
    if (rinc && !rempty) begin
      pend = q.pop_front();
      pend_v = 1;
      sb.push_back(pend);
      rinc_cnt++;
    end else pend_v = 0;
    if (!rst) begin
      sb.delete();
      pend_v = 0;
      prev_stall = 0;
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0; delivered = 0; rinc_cnt = 0;
    pend_v = 0; prev_stall = 0; pend = 0; prev_data = 0;
    r_rst = 0; rempty = 1; m_ready = 0; rdata = 0;
    // 1: reset holds everything off even with data available
    q.push_back(8'h11);
    for (int i = 0; i < 3; i++) begin
      step(1, 0);
      chk("rst_rinc", int'(o_rinc), 0);
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_level", int'(o_level), 0);
    end
    step(1, 1); chk("release_rinc", int'(o_rinc), 1);
    step(1, 1); chk("t1_n1_valid", int'(o_valid), 0);
    step(1, 1); chk("t1_n2_valid", int'(o_valid), 1); chk("t1_n2_data", int'(o_data), 8'h11);
    step(1, 1); chk("t1_n3_valid", int'(o_valid), 0);
    // 2: single word latency
    step(1, 1);
    q.push_back(8'hA5);
    step(1, 1); chk("t2_n_rinc", int'(o_rinc), 1);
    step(1, 1); chk("t2_n1_rinc", int'(o_rinc), 0); chk("t2_n1_valid", int'(o_valid), 0);
    step(1, 1); chk("t2_n2_valid", int'(o_valid), 1); chk("t2_n2_data", int'(o_data), 8'hA5);
    step(1, 1); chk("t2_n3_valid", int'(o_valid), 0); chk("t2_n3_level", int'(o_level), 0);
    // 3: full-throughput burst
    for (int i = 1; i <= 8; i++) q.push_back(8'(i));
    for (int i = 0; i < 10; i++) begin
      step(1, 1);
      chk("t3_rinc", int'(o_rinc), i < 8 ? 1 : 0);
      if (i >= 2) begin
        chk("t3_valid", int'(o_valid), 1);
        chk("t3_data", int'(o_data), i - 1);
      end
    end
    step(1, 1); chk("t3_end_valid", int'(o_valid), 0);
    // 4: backpressure stops at two credits, then drains one per cycle
    for (int i = 0; i < 5; i++) q.push_back(8'h21 + 8'(i));
    rinc_cnt = 0;
    for (int i = 0; i < 6; i++) step(0, 1);
    chk("t4_rinc_pulses", rinc_cnt, 2);
    chk("t4_level", int'(o_level), 2);
    chk("t4_valid", int'(o_valid), 1);
    chk("t4_head", int'(o_data), 8'h21);
    for (int i = 0; i < 5; i++) begin
      step(1, 1);
      chk("t4_drain_valid", int'(o_valid), 1);
      chk("t4_drain_data", int'(o_data), 8'h21 + i);
    end
    step(1, 1); chk("t4_end_valid", int'(o_valid), 0);
    // 5: toggling ready with the FIFO running dry mid-burst
    delivered = 0;
    for (int i = 0; i < 3; i++) q.push_back(8'h31 + 8'(i));
    for (int i = 0; i < 24; i++) begin
      if (i == 7) for (int k = 3; k < 6; k++) q.push_back(8'h31 + 8'(k));
      step(i % 2 == 0, 1);
    end
    chk("t5_delivered", delivered, 6);
    chk("t5_sb_empty", sb.size(), 0);
    // 6: reset while one word held and one in flight
    for (int i = 0; i < 5; i++) q.push_back(8'h41 + 8'(i));
    step(0, 1); chk("t6_c0_rinc", int'(o_rinc), 1);
    step(0, 1); chk("t6_c1_rinc", int'(o_rinc), 1);
    step(0, 0); chk("t6_rst_rinc", int'(o_rinc), 0); chk("t6_rst_level", int'(o_level), 1);
    step(0, 1);
    chk("t6_post_valid", int'(o_valid), 0);
    chk("t6_post_level", int'(o_level), 0);
    chk("t6_resume_rinc", int'(o_rinc), 1);
    delivered = 0;
    for (int i = 0; i < 8; i++) step(1, 1);
    chk("t6_delivered", delivered, 3);
    chk("t6_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
